// File: rtl/multicycle_control_unit.sv
// Control FSM for the shared multi-cycle RV32I datapath (one ALU, unified memory).
// Steps FETCH -> DECODE -> EXEC -> [MEM] -> [WB], counts retired instructions and
// halts in TRAP on an illegal opcode or when memory does not answer in time.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode_i,
  input  logic             mem_ready_i,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             addr_src_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             reg_write_o,
  output logic [1:0]       result_src_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             funct_override_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] instret_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // The wait counter holds the number of wait cycles already spent; the cycle in
  // which it equals WAIT_LAST is the MEM_TIMEOUT-th wait, where ready still wins.
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT == 0) ? '0 : WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        trap_cause, next_cause;
  logic [CNT_W-1:0]  instret;
  logic              retire, waiting, timeout_hit, is_legal;
  logic              mem_read, mem_write, ir_write, pc_write, reg_write;

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

  // Opcode legality check used in DECODE.
  always_comb begin
    is_legal = 1'b0;
    case (opcode_i)
      OP_R, OP_I, OP_LW, OP_SW, OP_LUI, OP_JALR, OP_JAL: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  end

  // Next-state, retire and trap-cause decision.
  always_comb begin
    next_state = state;
    next_cause = trap_cause;
    retire     = 1'b0;
    waiting    = 1'b0;
    case (state)
      S_FETCH: begin
        if (mem_ready_i) next_state = S_DECODE;
        else if (timeout_hit) begin
          next_state = S_TRAP;
          next_cause = 2'b10;
        end else waiting = 1'b1;
      end
      S_DECODE: begin
        if (is_legal) next_state = S_EXEC;
        else begin
          next_state = S_TRAP;
          next_cause = 2'b01;
        end
      end
      S_EXEC: begin
        case (opcode_i)
          OP_R, OP_I, OP_LUI: next_state = S_WB;
          OP_LW, OP_SW:       next_state = S_MEM;
          OP_JAL, OP_JALR: begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end
          default: begin
            next_state = S_TRAP;
            next_cause = 2'b01;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ready_i) begin
          if (opcode_i == OP_LW) next_state = S_WB;
          else begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end
        end else if (timeout_hit) begin
          next_state = S_TRAP;
          next_cause = 2'b10;
        end else waiting = 1'b1;
      end
      S_WB: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
  end

  // State, wait counter, trap cause and retired-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      trap_cause <= 2'b00;
      instret    <= '0;
    end else begin
      state      <= next_state;
      trap_cause <= next_cause;
      if (retire) instret <= instret + CNT_W'(1);
      if (next_state != state) wait_cnt <= '0;
      else if (waiting && wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Datapath controls for the current state (Mealy on mem_ready_i in FETCH/MEM).
  always_comb begin
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    reg_write        = 1'b0;
    addr_src_o       = 1'b0;
    pc_src_o         = 1'b0;
    result_src_o     = 2'b00;
    alu_src_a_o      = 2'b00;
    alu_src_b_o      = 2'b00;
    alu_op_o         = 3'b000;
    funct_override_o = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready_i) begin
          ir_write         = 1'b1;
          pc_write         = 1'b1;
          alu_src_b_o      = 2'b10;
          alu_op_o         = 3'b001;
          funct_override_o = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a_o      = 2'b11;
        alu_src_b_o      = 2'b01;
        alu_op_o         = 3'b001;
        funct_override_o = 1'b1;
      end
      S_EXEC: begin
        case (opcode_i)
          OP_R: begin
            alu_src_a_o = 2'b01;
            alu_op_o    = 3'b000;
          end
          OP_I, OP_LUI, OP_LW, OP_SW: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b01;
            case (opcode_i)
              OP_I:    alu_op_o = 3'b001;
              OP_LUI:  alu_op_o = 3'b010;
              OP_LW:   alu_op_o = 3'b100;
              default: alu_op_o = 3'b011;
            endcase
          end
          OP_JAL: begin
            pc_write     = 1'b1;
            pc_src_o     = 1'b1;
            reg_write    = 1'b1;
            result_src_o = 2'b10;
          end
          OP_JALR: begin
            alu_src_a_o  = 2'b01;
            alu_src_b_o  = 2'b01;
            alu_op_o     = 3'b110;
            pc_write     = 1'b1;
            reg_write    = 1'b1;
            result_src_o = 2'b10;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        addr_src_o = 1'b1;
        mem_read   = (opcode_i == OP_LW);
        mem_write  = (opcode_i == OP_SW);
      end
      S_WB: begin
        reg_write    = 1'b1;
        result_src_o = (opcode_i == OP_LW) ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

  // Strobes are masked directly by reset so nothing fires while it is held low.
  assign mem_read_o   = mem_read  & reset;
  assign mem_write_o  = mem_write & reset;
  assign ir_write_o   = ir_write  & reset;
  assign pc_write_o   = pc_write  & reset;
  assign reg_write_o  = reg_write & reset;
  assign trap_o       = (state == S_TRAP);
  assign trap_cause_o = trap_cause;
  assign instret_o    = instret;
  assign state_o      = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (MEM_TIMEOUT=4, CNT_W=4).
// Expected per-cycle outputs are queued when stimulus is applied and popped
// when the outputs are sampled one time unit after the falling edge.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       ready = 1'b0;
  logic       mem_read, mem_write, addr_src, ir_write, pc_write, pc_src, reg_write;
  logic [1:0] result_src, src_a, src_b, cause;
  logic [2:0] alu_op, state;
  logic       override, trap;
  logic [3:0] instret;

  typedef struct {
    logic [2:0] state;
    logic       mem_read, mem_write, addr_src, ir_write, pc_write, pc_src, reg_write;
    logic [1:0] result_src, src_a, src_b;
    logic [2:0] alu_op;
    logic       override, trap;
    logic [1:0] cause;
    logic [3:0] instret;
    logic       chk_sel, chk_res;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] exp_instret = 4'd0;
  int         n_asserts = 0;
  int         n_fail = 0;
  int         step = 0;

  multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode_i(opcode), .mem_ready_i(ready),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .addr_src_o(addr_src),
    .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_src_o(pc_src),
    .reg_write_o(reg_write), .result_src_o(result_src), .alu_src_a_o(src_a),
    .alu_src_b_o(src_b), .alu_op_o(alu_op), .funct_override_o(override),
    .trap_o(trap), .trap_cause_o(cause), .instret_o(instret), .state_o(state)
  );

  always #5 clk = ~clk;

  // Expected-value builders: anything not set explicitly is expected to be 0.
  function automatic exp_t base(input logic [2:0] st);
    exp_t e;
    e = '{state: st, mem_read: 0, mem_write: 0, addr_src: 0, ir_write: 0, pc_write: 0,
          pc_src: 0, reg_write: 0, result_src: 0, src_a: 0, src_b: 0, alu_op: 0,
          override: 0, trap: 0, cause: 0, instret: exp_instret, chk_sel: 1, chk_res: 1};
    return e;
  endfunction

  function automatic exp_t fetch_exp(input logic rdy);
    exp_t e = base(3'd0);
    e.mem_read = 1'b1;
    e.chk_res  = 1'b0;
    if (rdy) begin
      e.ir_write = 1'b1; e.pc_write = 1'b1; e.src_b = 2'b10; e.alu_op = 3'b001; e.override = 1'b1;
    end else e.chk_sel = 1'b0;
    return e;
  endfunction

  function automatic exp_t decode_exp();
    exp_t e = base(3'd1);
    e.src_a = 2'b11; e.src_b = 2'b01; e.alu_op = 3'b001; e.override = 1'b1;
    return e;
  endfunction

  function automatic exp_t exec_exp(input logic [6:0] op);
    exp_t e = base(3'd2);
    case (op)
      OP_R:   begin e.src_a = 2'b01; e.alu_op = 3'b000; end
      OP_I:   begin e.src_a = 2'b01; e.src_b = 2'b01; e.alu_op = 3'b001; end
      OP_LUI: begin e.src_a = 2'b01; e.src_b = 2'b01; e.alu_op = 3'b010; end
      OP_LW:  begin e.src_a = 2'b01; e.src_b = 2'b01; e.alu_op = 3'b100; end
      OP_SW:  begin e.src_a = 2'b01; e.src_b = 2'b01; e.alu_op = 3'b011; end
      OP_JAL: begin e.pc_write = 1; e.pc_src = 1; e.reg_write = 1; e.result_src = 2'b10; end
      default: begin
        e.src_a = 2'b01; e.src_b = 2'b01; e.alu_op = 3'b110;
        e.pc_write = 1; e.reg_write = 1; e.result_src = 2'b10;
      end
    endcase
    return e;
  endfunction

  function automatic exp_t mem_exp(input logic [6:0] op);
    exp_t e = base(3'd3);
    e.addr_src  = 1'b1;
    e.mem_read  = (op == OP_LW);
    e.mem_write = (op == OP_SW);
    e.chk_sel   = 1'b0;
    e.chk_res   = 1'b0;
    return e;
  endfunction

  function automatic exp_t wb_exp(input logic [6:0] op);
    exp_t e = base(3'd4);
    e.reg_write  = 1'b1;
    e.result_src = (op == OP_LW) ? 2'b01 : 2'b00;
    return e;
  endfunction

  function automatic exp_t trap_exp(input logic [1:0] c);
    exp_t e = base(3'd7);
    e.trap = 1'b1; e.cause = c;
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e = base(3'd0);
    e.instret = 4'd0; e.chk_sel = 1'b0; e.chk_res = 1'b0;
    return e;
  endfunction

  task automatic checkField(input string tag, input int unsigned obs, input int unsigned expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL step %0d %s: observed %0d expected %0d", step, tag, obs, expv);
    end
  endtask

  // Drive inputs on the falling edge and queue what the outputs must show.
  task automatic applyStimulus(input logic rst, input logic [6:0] op, input logic rdy, input exp_t e);
    @(negedge clk);
    reset  = rst;
    opcode = op;
    ready  = rdy;
    sb_q.push_back(e);
  endtask

  // Sample one unit after the falling edge and compare against the queue head.
  task automatic checkOutput();
    exp_t e;
    #1;
    step++;
    if (sb_q.size() == 0) begin
      n_asserts++;
      n_fail++;
      $display("[TB] FAIL step %0d scoreboard: observed empty queue, required an entry", step);
      return;
    end
    e = sb_q.pop_front();
    checkField("state", state, e.state);
    checkField("mem_read", mem_read, e.mem_read);
    checkField("mem_write", mem_write, e.mem_write);
    checkField("ir_write", ir_write, e.ir_write);
    checkField("pc_write", pc_write, e.pc_write);
    checkField("reg_write", reg_write, e.reg_write);
    checkField("addr_src", addr_src, e.addr_src);
    checkField("trap", trap, e.trap);
    checkField("cause", cause, e.cause);
    checkField("instret", instret, e.instret);
    if (e.chk_sel) begin
      checkField("pc_src", pc_src, e.pc_src);
      checkField("src_a", src_a, e.src_a);
      checkField("src_b", src_b, e.src_b);
      checkField("alu_op", alu_op, e.alu_op);
      checkField("override", override, e.override);
    end
    if (e.chk_res) checkField("result_src", result_src, e.result_src);
  endtask

  task automatic cycle(input logic rst, input logic [6:0] op, input logic rdy, input exp_t e);
    applyStimulus(rst, op, rdy, e);
    checkOutput();
  endtask

  // One full instruction; mem_wait = cycles mem_ready_i is held low in MEM.
  task automatic runInstr(input logic [6:0] op, input int mem_wait);
    cycle(1'b1, op, 1'b1, fetch_exp(1'b1));
    cycle(1'b1, op, 1'b1, decode_exp());
    cycle(1'b1, op, 1'b1, exec_exp(op));
    if (op == OP_LW || op == OP_SW) begin
      for (int i = 0; i < mem_wait; i++) cycle(1'b1, op, 1'b0, mem_exp(op));
      cycle(1'b1, op, 1'b1, mem_exp(op));
    end
    if (op == OP_R || op == OP_I || op == OP_LUI || op == OP_LW) cycle(1'b1, op, 1'b1, wb_exp(op));
    exp_instret = exp_instret + 4'd1;
  endtask

  initial begin
    // Reset state, strobes masked while reset is low.
    cycle(1'b0, OP_R, 1'b1, reset_exp());
    cycle(1'b0, OP_R, 1'b0, reset_exp());

    // Main instruction mix with memory answering at once, LW waiting 3 cycles.
    runInstr(OP_R, 0);
    runInstr(OP_LW, 3);
    runInstr(OP_SW, 0);
    runInstr(OP_JAL, 0);
    runInstr(OP_JALR, 0);
    runInstr(OP_I, 0);
    runInstr(OP_LUI, 0);

    // Ready on the last allowed wait cycle of FETCH: no trap, DECODE follows.
    for (int i = 0; i < 3; i++) cycle(1'b1, OP_R, 1'b0, fetch_exp(1'b0));
    cycle(1'b1, OP_R, 1'b1, fetch_exp(1'b1));
    cycle(1'b1, OP_R, 1'b1, decode_exp());
    cycle(1'b1, OP_R, 1'b1, exec_exp(OP_R));
    cycle(1'b1, OP_R, 1'b1, wb_exp(OP_R));
    exp_instret = exp_instret + 4'd1;

    // Counter up to 15, then one more wraps it to 0.
    for (int i = 0; i < 7; i++) runInstr(OP_I, 0);
    runInstr(OP_R, 0);
    runInstr(OP_R, 0);

    // Illegal opcode traps with cause 01 and stays halted; reset clears it.
    cycle(1'b1, OP_BAD, 1'b1, fetch_exp(1'b1));
    cycle(1'b1, OP_BAD, 1'b1, decode_exp());
    for (int i = 0; i < 20; i++) cycle(1'b1, OP_BAD, 1'($urandom_range(0, 1)), trap_exp(2'b01));
    exp_instret = 4'd0;
    cycle(1'b0, OP_R, 1'b0, reset_exp());

    // FETCH memory timeout after 4 wait cycles traps with cause 10.
    for (int i = 0; i < 4; i++) cycle(1'b1, OP_R, 1'b0, fetch_exp(1'b0));
    for (int i = 0; i < 3; i++) cycle(1'b1, OP_R, 1'b0, trap_exp(2'b10));
    cycle(1'b0, OP_R, 1'b0, reset_exp());

    // Reset asserted in the middle of a MEM wait drops strobes immediately.
    cycle(1'b1, OP_LW, 1'b1, fetch_exp(1'b1));
    cycle(1'b1, OP_LW, 1'b1, decode_exp());
    cycle(1'b1, OP_LW, 1'b1, exec_exp(OP_LW));
    cycle(1'b1, OP_LW, 1'b0, mem_exp(OP_LW));
    cycle(1'b0, OP_LW, 1'b0, reset_exp());
    runInstr(OP_SW, 2);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion, required $finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Moore/Mealy FSM that sequences the shared multi-cycle RV32I datapath: one ALU, one unified memory, register file, PC/IR/ALUOut/MDR registers. Per instruction it steps FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB]. It drives the 3-bit ALU_Op code consumed by the existing ALU control decoder and a funct override for internal PC arithmetic. It also tracks retired instructions and traps on illegal opcodes or memory timeouts.

Parameters:
MEM_TIMEOUT, 15, max wait cycles for mem_ready_i per access; 0 disables the timeout.
CNT_W, 32, width of instret_o.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
opcode_i  input  7  IR[6:0]; valid from DECODE onward
mem_ready_i  input  1  memory completes the current read/write this cycle
mem_read_o  output  1  memory read strobe
mem_write_o  output  1  memory write strobe
addr_src_o  output  1  0 = PC, 1 = ALUOut as memory address
ir_write_o  output  1  load IR and OldPC
pc_write_o  output  1  load PC
pc_src_o  output  1  0 = ALU result (combinational), 1 = ALUOut
reg_write_o  output  1  register file write enable
result_src_o  output  2  00 = ALUOut, 01 = MDR, 10 = PC
alu_src_a_o  output  2  00 = PC, 01 = rs1, 11 = OldPC
alu_src_b_o  output  2  00 = rs2, 01 = imm, 10 = const 4
alu_op_o  output  3  ALU_Op code to ALU control
funct_override_o  output  1  datapath forces funct7 = 0 and funct3 = 000 (ALU add)
trap_o  output  1  core halted
trap_cause_o  output  2  00 = none, 01 = illegal opcode, 10 = memory timeout
instret_o  output  CNT_W  retired instruction count
state_o  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7

Behaviour:
- Reset (reset=0, async): state = FETCH, wait counter = 0, instret_o = 0, trap_o = 0, trap_cause_o = 00. While reset = 0, every strobe is forced to 0: mem_read, mem_write, ir_write, pc_write, reg_write.
- Any output not listed for a state is 0. In FETCH and MEM the select outputs are don't-care unless listed.
- Supported opcodes:
  - R 0110011 -> alu_op 000
  - I 0010011 -> 001
  - LW 0000011 -> 100
  - SW 0100011 -> 011
  - LUI 0110111 -> 010
  - JALR 1100111 -> 110
  - JAL 1101111 -> add via override
- FETCH: mem_read=1, addr_src=0.
  - On mem_ready_i: ir_write=1 and pc_write=1 with pc_src=0, src_a=00, src_b=10, alu_op=001, override=1 (PC+4). Go to DECODE.
  - Otherwise stay in FETCH; the wait counter increments.
- DECODE: src_a=11, src_b=01, alu_op=001, override=1. ALUOut captures OldPC+imm (JAL target).
  - Illegal opcode -> TRAP, cause 01.
  - Otherwise -> EXEC.
- EXEC, per opcode:
  - R: src_a=01, src_b=00. -> WB.
  - I, LUI: src_a=01, src_b=01. -> WB.
  - LW, SW: src_a=01, src_b=01. -> MEM.
  - JAL: pc_write=1, pc_src=1, reg_write=1, result_src=10 (PC = OldPC+4 before the edge). -> FETCH, retire.
  - JALR: src_a=01, src_b=01, alu_op 110, pc_write=1, pc_src=0, reg_write=1, result_src=10. -> FETCH, retire.
  - Writes in EXEC use pre-edge values.
- MEM: addr_src=1; LW holds mem_read=1, SW holds mem_write=1 until mem_ready_i.
  - On ready: LW -> WB; SW -> FETCH, retire.
- WB: reg_write=1, result_src=01 for LW, otherwise 00. -> FETCH, retire.
- Retire: instret_o increments by 1 on the transition edge and wraps 2^CNT_W-1 -> 0.
- Wait counter (FETCH and MEM only):
  - Clears on every state change.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with mem_ready_i still 0, go to TRAP, cause 10.
  - mem_ready_i in the same cycle the counter hits the limit wins: no trap.
- TRAP: all strobes 0, trap_o=1, cause held, instret frozen. Exits only via reset.
- Reset mid-operation aborts immediately; no strobe is emitted after reset falls.
- Latency with mem_ready_i tied to 1:
  - R/I/LUI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - JAL/JALR: 3 cycles.

Test Plan:
- Reset, ready=1, R-type 0110011 -> states 0,1,2,4,0; alu_op=000 in EXEC; reg_write only in WB; instret=1 after 4 cycles.
- LW with ready delayed 3 cycles in MEM -> mem_read held 4 cycles with addr_src=1; WB result_src=01; 5+3 total cycles; SW variant -> mem_write, no reg_write, retire after MEM.
- JAL then JALR -> EXEC shows pc_write=1 and reg_write=1 with result_src=10; pc_src=1 for JAL, 0 for JALR; alu_op=110 for JALR; 3 cycles each.
- Opcode 1111111 in DECODE -> TRAP next edge, trap_o=1, cause=01, all strobes 0 for 20 cycles; reset releases to FETCH with instret=0.
- MEM_TIMEOUT=4, ready held 0 in FETCH -> trap cause 10 after 4 wait cycles; repeat with ready arriving exactly on the limit cycle -> no trap, DECODE next.
- Preload instret = 2^CNT_W-1 (CNT_W=4, 15 instructions) then one more -> wraps to 0; async reset asserted mid-MEM -> strobes drop the same cycle, state_o=0.
